// File: rtl/rnn_pkg.sv
// Shared types and helpers for the RNN timestep controller: FSM states,
// fixed-point format constant, and the 16-bit saturating clamp.
package rnn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MAC_X,
        MAC_H,
        FIN,
        COMMIT,
        DENSE,
        OUT,
        DONE
    } state_t;

    localparam int unsigned FRAC  = 8;
    localparam int unsigned SAT_W = 64;

    typedef struct packed {
        logic        clamped;
        logic [15:0] val;
    } sat_t;

    // Callers sign-extend their accumulator sum to SAT_W bits before clamping.
    function automatic sat_t sat16(input logic signed [SAT_W-1:0] v);
        sat_t r;
        if (v > 64'sd32767) begin
            r.clamped = 1'b1;
            r.val     = 16'h7FFF;
        end else if (v < -64'sd32768) begin
            r.clamped = 1'b1;
            r.val     = 16'h8000;
        end else begin
            r.clamped = 1'b0;
            r.val     = v[15:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/rnn_mac.sv
// Signed 16x16 multiply-accumulate: each enabled cycle adds the product
// shifted right (floor) by FRAC into a wrapping ACC_W-bit accumulator.
module rnn_mac #(
    parameter int unsigned ACC_W = 32,
    parameter int unsigned FRAC  = rnn_pkg::FRAC
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [15:0]      a,
    input  logic signed [15:0]      b,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [31:0]      w_prod;
    logic signed [31:0]      w_term;
    logic signed [ACC_W-1:0] r_acc;

    assign w_prod = 32'(a) * 32'(b);
    assign w_term = w_prod >>> FRAC;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (clr) begin
            r_acc <= '0;
        end else if (en) begin
            r_acc <= r_acc + ACC_W'(w_term);
        end
    end

    assign acc = r_acc;

endmodule

// File: rtl/rnn_sequencer.sv
// RNN timestep controller: computes every hidden unit with ReLU, commits the
// new hidden vector, then evaluates the dense output layer.
module rnn_sequencer #(
    parameter int unsigned IN_BITS  = 2,
    parameter int unsigned HID_BITS = 4,
    parameter int unsigned FRAC     = rnn_pkg::FRAC,
    parameter int unsigned ACC_W    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                ovf,
    output logic [15:0]         y_out,
    output logic [IN_BITS-1:0]  x_sel,
    input  logic [15:0]         x_data,
    output logic [IN_BITS-1:0]  w0_sel_r,
    output logic [HID_BITS-1:0] w0_sel_c,
    input  logic [15:0]         w0_data,
    output logic [HID_BITS-1:0] w1_sel_r,
    output logic [HID_BITS-1:0] w1_sel_c,
    input  logic [15:0]         w1_data,
    output logic [HID_BITS-1:0] b_sel,
    input  logic [15:0]         b_data,
    output logic [HID_BITS-1:0] h_sel,
    input  logic [15:0]         h_data,
    output logic                h_write,
    output logic [15:0]         h_wdata,
    output logic [HID_BITS-1:0] d_sel,
    input  logic [15:0]         d_data,
    input  logic [15:0]         dense_bias
);

    import rnn_pkg::*;

    localparam int unsigned IN_LEN  = 2 ** IN_BITS;
    localparam int unsigned HID_LEN = 2 ** HID_BITS;

    state_t                  r_state;
    state_t                  w_next;
    logic [HID_BITS-1:0]     r_cnt;
    logic [HID_BITS-1:0]     r_j;
    logic [15:0]             r_buf [HID_LEN];
    logic                    r_ovf;
    logic [15:0]             r_y;

    logic                    w_mac_clr;
    logic                    w_mac_en;
    logic signed [15:0]      w_mac_a;
    logic signed [15:0]      w_mac_b;
    logic signed [ACC_W-1:0] w_acc;

    logic                    w_last_in;
    logic                    w_last_hid;
    logic signed [ACC_W-1:0] w_fin_sum;
    logic signed [ACC_W-1:0] w_out_sum;
    sat_t                    w_fin_sat;
    sat_t                    w_out_sat;
    logic [15:0]             w_relu;

    rnn_mac #(
        .ACC_W (ACC_W),
        .FRAC  (FRAC)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_mac_clr),
        .en    (w_mac_en),
        .a     (w_mac_a),
        .b     (w_mac_b),
        .acc   (w_acc)
    );

    assign w_last_in  = (r_cnt == HID_BITS'(IN_LEN - 1));
    assign w_last_hid = (r_cnt == '1);
    assign w_fin_sum  = w_acc + ACC_W'(signed'(b_data));
    assign w_out_sum  = w_acc + ACC_W'(signed'(dense_bias));
    assign w_fin_sat  = sat16(SAT_W'(w_fin_sum));
    assign w_out_sat  = sat16(SAT_W'(w_out_sum));
    assign w_relu     = w_fin_sat.val[15] ? '0 : w_fin_sat.val;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        busy      = (r_state != IDLE);
        done      = 1'b0;
        x_sel     = '0;
        w0_sel_r  = '0;
        w0_sel_c  = '0;
        w1_sel_r  = '0;
        w1_sel_c  = '0;
        b_sel     = '0;
        h_sel     = '0;
        h_write   = 1'b0;
        h_wdata   = '0;
        d_sel     = '0;
        w_mac_clr = 1'b0;
        w_mac_en  = 1'b0;
        w_mac_a   = '0;
        w_mac_b   = '0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_mac_clr = 1'b1;
                    w_next    = MAC_X;
                end
            end
            MAC_X: begin
                x_sel    = r_cnt[IN_BITS-1:0];
                w0_sel_r = r_cnt[IN_BITS-1:0];
                w0_sel_c = r_j;
                w_mac_en = 1'b1;
                w_mac_a  = x_data;
                w_mac_b  = w0_data;
                if (w_last_in) w_next = MAC_H;
            end
            MAC_H: begin
                h_sel    = r_cnt;
                w1_sel_r = r_cnt;
                w1_sel_c = r_j;
                w_mac_en = 1'b1;
                w_mac_a  = h_data;
                w_mac_b  = w1_data;
                if (w_last_hid) w_next = FIN;
            end
            FIN: begin
                b_sel     = r_j;
                w_mac_clr = 1'b1;
                w_next    = (r_j == '1) ? COMMIT : MAC_X;
            end
            COMMIT: begin
                // Write strobe drops with reset so an aborted commit leaves
                // the current entry untouched.
                h_write = rst_n;
                h_sel   = r_cnt;
                h_wdata = r_buf[r_cnt];
                if (w_last_hid) w_next = DENSE;
            end
            DENSE: begin
                d_sel    = r_cnt;
                w_mac_en = 1'b1;
                w_mac_a  = d_data;
                w_mac_b  = r_buf[r_cnt];
                if (w_last_hid) w_next = OUT;
            end
            OUT: begin
                w_next = DONE;
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_j   <= '0;
            r_ovf <= 1'b0;
            r_y   <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_cnt <= '0;
                        r_j   <= '0;
                        r_ovf <= 1'b0;
                    end
                end
                MAC_X: r_cnt <= w_last_in ? '0 : r_cnt + 1'b1;
                MAC_H, COMMIT, DENSE: r_cnt <= r_cnt + 1'b1;
                FIN: begin
                    r_cnt <= '0;
                    r_j   <= r_j + 1'b1;
                    // Negative results are zeroed by ReLU; only the upper clamp flags.
                    if (w_fin_sat.clamped && !w_fin_sat.val[15]) r_ovf <= 1'b1;
                end
                OUT: begin
                    r_y <= w_out_sat.val;
                    if (w_out_sat.clamped) r_ovf <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && r_state == FIN) begin
            r_buf[r_j] <= w_relu;
        end
    end

    assign ovf   = r_ovf;
    assign y_out = r_y;

endmodule

// File: tb/tb_rnn_sequencer.sv
// Self-checking bench for rnn_sequencer: tensor storage models, a behavioural
// timestep model, a per-cycle compare process and directed scenarios.
module tb_rnn_sequencer;

    localparam int IN_LEN  = 4;
    localparam int HID_LEN = 16;
    localparam int LAT     = HID_LEN * (IN_LEN + HID_LEN + 1) + 2 * HID_LEN + 1;
    localparam int CSTART  = HID_LEN * (IN_LEN + HID_LEN + 1);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        h_clr = 1'b0;
    logic        busy, done, ovf, h_write;
    logic [15:0] y_out, h_wdata;
    logic [1:0]  x_sel, w0_sel_r;
    logic [3:0]  w0_sel_c, w1_sel_r, w1_sel_c, b_sel, h_sel, d_sel;
    logic [15:0] x_data, w0_data, w1_data, b_data, h_data, d_data;
    logic [15:0] dense_bias;

    logic [15:0] x_mem  [IN_LEN];
    logic [15:0] w0_mem [IN_LEN][HID_LEN];
    logic [15:0] w1_mem [HID_LEN][HID_LEN];
    logic [15:0] b_mem  [HID_LEN];
    logic [15:0] h_mem  [HID_LEN];
    logic [15:0] d_mem  [HID_LEN];
    logic [15:0] prev_h [HID_LEN];

    rnn_sequencer #(
        .IN_BITS  (2),
        .HID_BITS (4),
        .FRAC     (8),
        .ACC_W    (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .ovf        (ovf),
        .y_out      (y_out),
        .x_sel      (x_sel),
        .x_data     (x_data),
        .w0_sel_r   (w0_sel_r),
        .w0_sel_c   (w0_sel_c),
        .w0_data    (w0_data),
        .w1_sel_r   (w1_sel_r),
        .w1_sel_c   (w1_sel_c),
        .w1_data    (w1_data),
        .b_sel      (b_sel),
        .b_data     (b_data),
        .h_sel      (h_sel),
        .h_data     (h_data),
        .h_write    (h_write),
        .h_wdata    (h_wdata),
        .d_sel      (d_sel),
        .d_data     (d_data),
        .dense_bias (dense_bias)
    );

    always #5 clk = ~clk;

    assign x_data  = x_mem[x_sel];
    assign w0_data = w0_mem[w0_sel_r][w0_sel_c];
    assign w1_data = w1_mem[w1_sel_r][w1_sel_c];
    assign b_data  = b_mem[b_sel];
    assign h_data  = h_mem[h_sel];
    assign d_data  = d_mem[d_sel];

    always @(posedge clk) begin
        if (h_clr) begin
            for (int i = 0; i < HID_LEN; i++) h_mem[i] <= '0;
        end else if (h_write) begin
            h_mem[h_sel] <= h_wdata;
        end
    end

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // Behavioural model of one timestep from the current tensor contents.
    logic [15:0] m_h [HID_LEN];
    logic [15:0] m_y;
    bit          m_ovf;

    function automatic longint sx(input logic [15:0] v);
        return longint'(signed'(v));
    endfunction

    function automatic longint mulq(input logic [15:0] a, input logic [15:0] b);
        return (sx(a) * sx(b)) >>> 8;
    endfunction

    function automatic void model();
        longint acc;
        m_ovf = 1'b0;
        for (int j = 0; j < HID_LEN; j++) begin
            acc = 0;
            for (int i = 0; i < IN_LEN; i++)  acc += mulq(x_mem[i], w0_mem[i][j]);
            for (int k = 0; k < HID_LEN; k++) acc += mulq(h_mem[k], w1_mem[k][j]);
            acc += sx(b_mem[j]);
            if (acc > 32767) begin
                m_h[j] = 16'h7FFF;
                m_ovf  = 1'b1;
            end else if (acc < 0) begin
                m_h[j] = '0;
            end else begin
                m_h[j] = 16'(acc);
            end
        end
        acc = 0;
        for (int k = 0; k < HID_LEN; k++) acc += mulq(d_mem[k], m_h[k]);
        acc += sx(dense_bias);
        if (acc > 32767) begin
            m_y = 16'h7FFF; m_ovf = 1'b1;
        end else if (acc < -32768) begin
            m_y = 16'h8000; m_ovf = 1'b1;
        end else begin
            m_y = 16'(acc);
        end
    endfunction

    // ofs = edges since the accepted start (-1 when idle).
    int          ofs = -1;
    bit          chk_en = 1'b0;
    logic [15:0] y_now = '0;
    bit          ovf_now = 1'b0;
    bit          hw_exp;

    always @(posedge clk) begin
        if (!rst_n) begin
            ofs = -1; y_now = '0; ovf_now = 1'b0; chk_en = 1'b1;
        end else if (ofs < 0) begin
            if (start) begin
                ofs = 0;
                model();
            end
        end else if (ofs == LAT) begin
            ofs = -1;
        end else begin
            ofs++;
            if (ofs == LAT) begin
                y_now   = m_y;
                ovf_now = m_ovf;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(ofs >= 0));
            chk("done", 32'(done), 32'(ofs == LAT));
            hw_exp = (ofs >= CSTART) && (ofs < CSTART + HID_LEN) && rst_n;
            chk("h_write", 32'(h_write), 32'(hw_exp));
            if (hw_exp) begin
                chk("h_sel", 32'(h_sel), 32'(ofs - CSTART));
                chk("h_wdata", 32'(h_wdata), 32'(m_h[ofs - CSTART]));
            end
            chk("y_out", 32'(y_out), 32'(y_now));
            if (ofs < 0 || ofs == LAT) chk("ovf", 32'(ovf), 32'(ovf_now));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        for (int i = 0; i < IN_LEN; i++) begin
            x_mem[i] = '0;
            for (int j = 0; j < HID_LEN; j++) w0_mem[i][j] = '0;
        end
        for (int k = 0; k < HID_LEN; k++) begin
            b_mem[k] = '0;
            d_mem[k] = '0;
            for (int j = 0; j < HID_LEN; j++) w1_mem[k][j] = '0;
        end
        dense_bias = '0;
    endtask

    task automatic run_step(input int pulse_at);
        int lat;
        int ndone;
        lat = 0;
        ndone = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ovf_cleared_on_start", 32'(ovf), 32'd0);
        for (int c = 1; c <= LAT + 4; c++) begin
            tick();
            start = (c == pulse_at);
            if (done) begin
                ndone++;
                if (lat == 0) lat = c;
            end
        end
        start = 1'b0;
        chk("latency", 32'(lat), 32'd369);
        chk("done_count", 32'(ndone), 32'd1);
    endtask

    initial begin
        clear_all();
        rst_n = 1'b0;
        start = 1'b1;
        h_clr = 1'b1;
        repeat (2) tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_y", 32'(y_out), 32'd0);
        chk("rst_hwrite", 32'(h_write), 32'd0);
        rst_n = 1'b1;
        start = 1'b0;
        h_clr = 1'b0;
        tick();

        // Basic
        clear_all();
        x_mem[0] = 16'h0100;
        for (int j = 0; j < HID_LEN; j++) begin
            w0_mem[0][j] = 16'h0080;
            d_mem[j]     = 16'h0100;
        end
        run_step(0);
        chk("basic_model_y", 32'(m_y), 32'h0800);
        chk("basic_y", 32'(y_out), 32'h0800);
        chk("basic_h0", 32'(h_mem[0]), 32'h0080);
        chk("basic_h15", 32'(h_mem[15]), 32'h0080);
        chk("basic_ovf", 32'(ovf), 32'd0);

        // ReLU
        clear_all();
        for (int j = 0; j < HID_LEN; j++) begin
            b_mem[j] = 16'hFF00;
            d_mem[j] = 16'h0100;
        end
        dense_bias = 16'h0180;
        run_step(0);
        chk("relu_y", 32'(y_out), 32'h0180);
        chk("relu_h7", 32'(h_mem[7]), 32'h0000);

        // Saturation
        clear_all();
        for (int i = 0; i < IN_LEN; i++) begin
            x_mem[i] = 16'h7FFF;
            for (int j = 0; j < HID_LEN; j++) w0_mem[i][j] = 16'h7FFF;
        end
        for (int j = 0; j < HID_LEN; j++) d_mem[j] = 16'h0100;
        run_step(0);
        chk("sat_h3", 32'(h_mem[3]), 32'h7FFF);
        chk("sat_ovf", 32'(ovf), 32'd1);
        chk("sat_y", 32'(y_out), 32'h7FFF);

        // Distinct hidden values, with a start pulse during busy
        clear_all();
        x_mem[0] = 16'h0100;
        for (int j = 0; j < HID_LEN; j++) begin
            w0_mem[0][j] = 16'(16 * (j + 1));
            d_mem[j]     = 16'h0100;
        end
        run_step(50);
        chk("ramp_h5", 32'(h_mem[5]), 32'h0060);
        for (int j = 0; j < HID_LEN; j++) prev_h[j] = h_mem[j];

        // Identity recurrence
        clear_all();
        for (int k = 0; k < HID_LEN; k++) begin
            w1_mem[k][k] = 16'h0100;
            d_mem[k]     = 16'h0100;
        end
        run_step(0);
        for (int j = 0; j < HID_LEN; j++) chk("recur_h", 32'(h_mem[j]), 32'(prev_h[j]));
        chk("recur_y", 32'(y_out), 32'h0880);

        // Reset during COMMIT at k = 5
        clear_all();
        x_mem[0] = 16'h0100;
        for (int j = 0; j < HID_LEN; j++) w0_mem[0][j] = 16'h0100;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 1000 && ofs != CSTART + 5; c++) tick();
        chk("commit_reach", 32'(ofs), 32'(CSTART + 5));
        rst_n = 1'b0;
        tick();
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_hwrite", 32'(h_write), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        for (int j = 0; j < 5; j++) chk("midrst_new", 32'(h_mem[j]), 32'h0100);
        for (int j = 5; j < HID_LEN; j++) chk("midrst_old", 32'(h_mem[j]), 32'(prev_h[j]));

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
